// File: rtl/riscv_rf_pkg.sv
// Shared types and constants for the multi-port integer register file.
package riscv_rf_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);
    localparam int REG_ZERO      = 0;

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xword_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus into the register file: read ports, write ports, issue and scoreboard.
interface reg_file_mp_if
    import riscv_rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NUM_RD*AW-1:0]   rs_addr;
    logic [NUM_RD*XLEN-1:0] rs_data;
    logic [NUM_RD-1:0]      rs_busy;
    logic [NUM_WR-1:0]      we;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rd;
    logic [NREGS-1:0]       busy_vec;

    modport master (
        output rs_addr, we, wr_addr, wr_data, issue_valid, issue_rd,
        input  rs_data, rs_busy, busy_vec
    );

    modport slave (
        input  rs_addr, we, wr_addr, wr_data, issue_valid, issue_rd,
        output rs_data, rs_busy, busy_vec
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: storage mux, write bypass (highest port wins), x0 and reset forcing.
module rf_read_port
    import riscv_rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                   rst_n_i,
    input  logic [AW-1:0]          rd_addr_i,
    input  logic [NREGS*XLEN-1:0]  regs_i,
    input  logic [NREGS-1:0]       busy_i,
    input  logic [NUM_WR-1:0]      we_i,
    input  logic [NUM_WR*AW-1:0]   wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0]        rd_data_o,
    output logic                   rd_busy_o
);

    logic            hit;
    logic [XLEN-1:0] byp_data;
    logic [XLEN-1:0] stored;
    logic            use_byp;

    // Later ports overwrite earlier matches so the highest-index writer is forwarded.
    always_comb begin
        hit      = 1'b0;
        byp_data = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (we_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
                hit      = 1'b1;
                byp_data = wr_data_i[j*XLEN +: XLEN];
            end
        end
    end

    assign stored  = regs_i[int'(rd_addr_i)*XLEN +: XLEN];
    assign use_byp = (BYPASS != 0) && hit;

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if (rst_n_i && (int'(rd_addr_i) != REG_ZERO)) begin
            rd_data_o = use_byp ? byp_data : stored;
            rd_busy_o = busy_i[rd_addr_i] && !use_byp;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write priority, optional bypass and a per-register busy scoreboard.
module reg_file_mp
    import riscv_rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_mp_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [NREGS*XLEN-1:0] regs_flat;

    // A new issue to a register supersedes a producer completing in the same cycle.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            busy_d[r] = busy_q[r];
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.we[j] && (int'(bus.wr_addr[j*AW +: AW]) == r)) begin
                    regs_d[r] = bus.wr_data[j*XLEN +: XLEN];
                    busy_d[r] = 1'b0;
                end
            end
            if (bus.issue_valid && (int'(bus.issue_rd) == r)) begin
                busy_d[r] = 1'b1;
            end
        end
        regs_d[REG_ZERO] = '0;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int r = 0; r < NREGS; r++) begin
            regs_flat[r*XLEN +: XLEN] = regs_q[r];
        end
    end

    assign bus.busy_vec = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        rf_read_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .NUM_WR (NUM_WR),
            .BYPASS (BYPASS)
        ) u_port (
            .rst_n_i   (rst_n),
            .rd_addr_i (bus.rs_addr[k*AW +: AW]),
            .regs_i    (regs_flat),
            .busy_i    (busy_q),
            .we_i      (bus.we),
            .wr_addr_i (bus.wr_addr),
            .wr_data_i (bus.wr_data),
            .rd_data_o (bus.rs_data[k*XLEN +: XLEN]),
            .rd_busy_o (bus.rs_busy[k])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Drives a bypassing and a non-bypassing two-write-port register file with the same stimulus
// and compares both against an array/bitmask model every cycle, plus hand-computed literals.
module tb_reg_file_mp;
    import riscv_rf_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic [9:0]  rsAddr;
    logic [1:0]  we;
    logic [9:0]  wrAddr;
    logic [63:0] wrData;
    logic        issueValid;
    reg_addr_t   issueRd;

    int passCount = 0;
    int checkCount = 0;
    bit started = 1'b0;
    bit done = 1'b0;

    xword_t      mMem [32];
    logic [31:0] mBusy;
    logic [31:0] nextBusy;

    always #5 clk = ~clk;

    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) ifB ();
    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) ifN ();

    assign ifB.rs_addr     = rsAddr;
    assign ifB.we          = we;
    assign ifB.wr_addr     = wrAddr;
    assign ifB.wr_data     = wrData;
    assign ifB.issue_valid = issueValid;
    assign ifB.issue_rd    = issueRd;
    assign ifN.rs_addr     = rsAddr;
    assign ifN.we          = we;
    assign ifN.wr_addr     = wrAddr;
    assign ifN.wr_data     = wrData;
    assign ifN.issue_valid = issueValid;
    assign ifN.issue_rd    = issueRd;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dutB (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (ifB.slave)
    );

    reg_file_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dutN (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (ifN.slave)
    );

    // Architectural model: registers as an array, scoreboard as a bitmask.
    always @(posedge clk) begin
        if (!rstN) begin
            for (int r = 0; r < 32; r++) mMem[r] <= '0;
            mBusy <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wrAddr[j*5 +: 5] != 0) mMem[wrAddr[j*5 +: 5]] <= wrData[j*32 +: 32];
            end
            nextBusy = mBusy;
            for (int j = 0; j < 2; j++) begin
                if (we[j]) nextBusy[wrAddr[j*5 +: 5]] = 1'b0;
            end
            if (issueValid) nextBusy[issueRd] = 1'b1;
            nextBusy[0] = 1'b0;
            mBusy <= nextBusy;
        end
    end

    function automatic xword_t expData(input bit byp, input int k);
        reg_addr_t a;
        xword_t v;
        a = rsAddr[k*5 +: 5];
        if (!rstN || a == 0) return '0;
        v = mMem[a];
        if (byp) begin
            for (int j = 0; j < 2; j++) begin
                if (we[j] && wrAddr[j*5 +: 5] == a) v = wrData[j*32 +: 32];
            end
        end
        return v;
    endfunction

    function automatic logic expBusy(input bit byp, input int k);
        reg_addr_t a;
        bit hit;
        a = rsAddr[k*5 +: 5];
        hit = 1'b0;
        if (!rstN || a == 0) return 1'b0;
        for (int j = 0; j < 2; j++) begin
            if (we[j] && wrAddr[j*5 +: 5] == a) hit = 1'b1;
        end
        return mBusy[a] && !(byp && hit);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (started && !done) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("cmpDataB%0d", k), 64'(ifB.rs_data[k*32 +: 32]), 64'(expData(1'b1, k)));
                checkOutput($sformatf("cmpDataN%0d", k), 64'(ifN.rs_data[k*32 +: 32]), 64'(expData(1'b0, k)));
                checkOutput($sformatf("cmpBusyB%0d", k), 64'(ifB.rs_busy[k]), 64'(expBusy(1'b1, k)));
                checkOutput($sformatf("cmpBusyN%0d", k), 64'(ifN.rs_busy[k]), 64'(expBusy(1'b0, k)));
            end
            checkOutput("cmpBusyVecB", 64'(ifB.busy_vec), 64'(mBusy));
            checkOutput("cmpBusyVecN", 64'(ifN.busy_vec), 64'(mBusy));
        end
    end

    task automatic applyStimulus(input logic [1:0] weV, input reg_addr_t a0, input xword_t d0,
                                 input reg_addr_t a1, input xword_t d1, input logic iv,
                                 input reg_addr_t ird, input reg_addr_t r0, input reg_addr_t r1,
                                 input logic rst = 1'b1);
        @(posedge clk);
        #1;
        rstN       = rst;
        we         = weV;
        wrAddr     = {a1, a0};
        wrData     = {d1, d0};
        issueValid = iv;
        issueRd    = ird;
        rsAddr     = {r1, r0};
        @(negedge clk);
    endtask

    task automatic idle(input reg_addr_t r0, input reg_addr_t r1);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
    endtask

    function automatic xword_t fillVal(input int r);
        return xword_t'(32'h1000_0000 + r * 257);
    endfunction

    initial begin
        rstN = 1'b0; we = '0; wrAddr = '0; wrData = '0;
        issueValid = 1'b0; issueRd = '0; rsAddr = '0;
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        started = 1'b1;

        for (int a = 0; a < 32; a++) begin
            idle(reg_addr_t'(a), reg_addr_t'(31 - a));
            checkOutput("t1ResetRead", ifB.rs_data, 64'h0);
        end
        checkOutput("t1ResetBusy", 64'(ifB.busy_vec), 64'h0);
        applyStimulus(2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        checkOutput("t1X0Bypass", ifB.rs_data, 64'h0);
        idle(5'd0, 5'd0);
        checkOutput("t1X0Stored", ifN.rs_data, 64'h0);

        applyStimulus(2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        checkOutput("t2BypassB", 64'(ifB.rs_data[31:0]), 64'h12345678);
        checkOutput("t2OldN", 64'(ifN.rs_data[31:0]), 64'h0);
        idle(5'd5, 5'd0);
        checkOutput("t2NextN", 64'(ifN.rs_data[31:0]), 64'h12345678);

        applyStimulus(2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h5555FFFF, 1'b0, 5'd0, 5'd7, 5'd7);
        checkOutput("t3BypassPrio", ifB.rs_data, 64'h5555FFFF_5555FFFF);
        checkOutput("t3OldN", ifN.rs_data, 64'h0);
        idle(5'd7, 5'd7);
        checkOutput("t3StoredPrio", ifN.rs_data, 64'h5555FFFF_5555FFFF);

        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        checkOutput("t4BusySet", 64'(ifB.busy_vec), 64'h200);
        checkOutput("t4RsBusyB", 64'(ifB.rs_busy), 64'h1);
        applyStimulus(2'b01, 5'd9, 32'h00000099, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
        checkOutput("t4BypassNotBusy", 64'(ifB.rs_busy), 64'h0);
        checkOutput("t4NoBypassBusy", 64'(ifN.rs_busy), 64'h1);
        idle(5'd9, 5'd0);
        checkOutput("t4BusyCleared", 64'(ifN.busy_vec), 64'h0);

        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
        applyStimulus(2'b01, 5'd9, 32'h00001234, 5'd0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
        checkOutput("t5SetWins", 64'(ifB.busy_vec), 64'h200);
        idle(5'd9, 5'd0);
        checkOutput("t5IssueX0", 64'(ifN.busy_vec), 64'h200);
        checkOutput("t5Data", 64'(ifN.rs_data[31:0]), 64'h1234);

        for (int r = 1; r < 32; r++) begin
            applyStimulus(2'b10, 5'd0, 32'h0, reg_addr_t'(r), fillVal(r), 1'b0, 5'd0, 5'd0, 5'd0);
        end
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd0, 5'd0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd0, 5'd0);
        idle(5'd3, 5'd31);
        checkOutput("t6Filled", ifN.rs_data, 64'h1000_1F1F_1000_0303);
        checkOutput("t6BusyMask", 64'(ifB.busy_vec), 64'h00100408);
        applyStimulus(2'b01, 5'd3, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 5'd31, 1'b0);
        checkOutput("t6ResetForce", ifB.rs_data, 64'h0);
        checkOutput("t6ResetBusyPort", 64'(ifB.rs_busy), 64'h0);
        idle(5'd3, 5'd31);
        checkOutput("t6AfterResetB", ifB.rs_data, 64'h0);
        checkOutput("t6AfterResetN", ifN.rs_data, 64'h0);
        checkOutput("t6AfterResetBusy", 64'(ifB.busy_vec), 64'h0);
        for (int a = 1; a < 32; a++) begin
            idle(reg_addr_t'(a), 5'd0);
            checkOutput("t6ZeroSweep", 64'(ifN.rs_data[31:0]), 64'h0);
        end

        done = 1'b1;
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file for the pipelined RISC-V core. It is the successor to the single-write, two-read file. Adds configurable width, depth, and read/write port counts, plus same-cycle write-to-read bypass, deterministic write-port priority and a per-register busy scoreboard for hazard detection. Sits between decode (reads, issue) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
NUM_RD, 2, number of read ports
NUM_WR, 1, number of write ports (1..4)
BYPASS, 1, 1 = a read returns data being written in the same cycle; 0 = a read returns the stored value
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
rs_addr  in  NUM_RD*AW  read addresses, port k in slice [k*AW +: AW]
rs_data  out  NUM_RD*XLEN  read data, port k in slice [k*XLEN +: XLEN]
rs_busy  out  NUM_RD  read port k's register has a pending producer
we  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*XLEN  write data
issue_valid  in  1  an instruction with a destination issues this cycle
issue_rd  in  AW  destination of the issuing instruction
busy_vec  out  NREGS  registered scoreboard, bit r = register r pending

Behaviour:
- Reset: the clock and reset are clk and rst_n; reset is synchronous and active-low.
  - On a rising edge with rst_n=0, all NREGS entries and busy_vec are cleared to 0.
  - While rst_n=0, we and issue_valid are ignored.
  - While rst_n=0, rs_data and rs_busy are forced to 0 combinationally.
- Register 0 is hardwired:
  - Reads of address 0 always return 0, even when bypassed.
  - Writes to address 0 are discarded.
  - busy_vec[0] is constant 0, and rs_busy for address 0 is 0.
- Reads are combinational, with zero-cycle latency from rs_addr to rs_data.
- Writes are registered: data is stored on the rising edge when we[j]=1 and wr_addr[j]!=0.
- Write conflict: several ports write the same address in one cycle → the highest-index port j wins, for both storage and bypass.
- Bypass (BYPASS=1): if any enabled write port targets rs_addr[k] (nonzero), rs_data[k] returns that port's wr_data (highest index wins). Otherwise rs_data[k] returns the stored value.
- No bypass (BYPASS=0): rs_data[k] returns the stored value. Newly written data is visible from the cycle after the write edge.
- Scoreboard, evaluated per register r≠0 at the rising edge:
  - Set: issue_valid=1 and issue_rd=r.
  - Clear: any we[j]=1 with wr_addr[j]=r.
  - Set and clear in the same cycle → set wins; the new producer supersedes the completing one.
  - Neither → hold.
  - issue_rd=0 has no effect.
- rs_busy[k] = busy_vec[rs_addr[k]] & ~(BYPASS & write to rs_addr[k] this cycle).
  - Data being bypassed is therefore not reported busy.
  - With BYPASS=0, rs_busy[k] follows busy_vec only.
- No out-of-range addresses are possible, because NREGS = 2^AW.
- Reset mid-operation: the pending write and issue in the reset cycle are dropped. The file is fully zero and non-busy on the next cycle.

Decomposition:
- Shared package riscv_rf_pkg holds:
  - XLEN_DEFAULT=32, NREGS_DEFAULT=32.
  - Typedef reg_addr_t (AW bits) and xword_t (XLEN bits).
  - Constant REG_ZERO=0.
- One sub-module, rf_read_port, is instantiated NUM_RD times in a generate loop. It contains:
  - the storage mux;
  - the bypass priority encode across NUM_WR ports;
  - the zero forcing;
  - the rs_busy term.
- Storage array and scoreboard stay in reg_file_mp.

Test Plan:
1. Reset then read all 32 addresses on both ports → all rs_data=0, busy_vec=0. Drive we=1, wr_addr=0, wr_data=0xDEADBEEF, then read x0 → 0.
2. Write x5=0x12345678, reading x5 in the same cycle. BYPASS=1 → rs_data=0x12345678 that cycle. BYPASS=0 → old value 0 that cycle, 0x12345678 next cycle.
3. NUM_WR=2: port0 writes x7=0xAAAA0000 and port1 writes x7=0x5555FFFF in the same cycle → stored and bypassed value is 0x5555FFFF.
4. issue_valid with issue_rd=9 → busy_vec[9]=1 next cycle and rs_busy for x9 =1. Write x9 → busy clears next cycle, and with BYPASS=1 rs_busy=0 during the write cycle.
5. Issue x9 and write x9 in the same cycle → busy_vec[9] stays 1. issue_rd=0 → busy_vec[0] stays 0.
6. Fill x1..x31 with nonzero values and set several busy bits, then drive rst_n=0 for one edge together with a write to x3 → all registers 0, busy_vec=0, and x3 not written.
